icache_bank_ctrl_seq: RTL and testbench

- Per-bank control sequencer inside each shared (L1.5) instruction-cache bank; one instance per bank.
- Consumes the enable / disable / flush / selective-flush request-ack pairs issued by the cache control unit on the bank control bus.
- Drains outstanding refills, walks or probes the bank tag RAM to invalidate lines, maintains the bank enable state, then acknowledges the request.

---
 rtl/icache_bank_ctrl_seq.sv | 203 ++++++++++++++++++++
 tb/tb_icache_bank_ctrl_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/icache_bank_ctrl_seq.sv
// rtl/icache_bank_ctrl_seq.sv - per-bank enable/disable/flush sequencer for an L1.5 icache bank
// Optional power-on tag clear walk: define ICACHE_INIT_FLUSH_EN.
module icache_bank_ctrl_seq #(
    parameter int SET_ID_WIDTH = 5,
    parameter int NB_WAYS      = 4,
    parameter int OFFSET_WIDTH = 4,
    localparam int TAG_WIDTH   = 32 - SET_ID_WIDTH - OFFSET_WIDTH
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             ctrl_req_enable_i,
    output logic                             ctrl_ack_enable_o,
    input  logic                             ctrl_req_disable_i,
    output logic                             ctrl_ack_disable_o,
    input  logic                             ctrl_flush_req_i,
    output logic                             ctrl_flush_ack_o,
    input  logic                             sel_flush_req_i,
    input  logic [31:0]                      sel_flush_addr_i,
    output logic                             sel_flush_ack_o,
    input  logic                             fetch_idle_i,
    output logic                             block_fetch_o,
    output logic                             cache_enabled_o,
    output logic                             tag_req_o,
    output logic                             tag_we_o,
    output logic [SET_ID_WIDTH-1:0]          tag_addr_o,
    output logic [NB_WAYS-1:0]               tag_way_be_o,
    output logic [TAG_WIDTH:0]               tag_wdata_o,
    input  logic [NB_WAYS*(TAG_WIDTH+1)-1:0] tag_rdata_i
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DRAIN   = 3'd1;
    localparam logic [2:0] WALK    = 3'd2;
    localparam logic [2:0] SEL_RD  = 3'd3;
    localparam logic [2:0] SEL_CMP = 3'd4;
    localparam logic [2:0] ACK     = 3'd5;

    localparam logic [1:0] OP_EN    = 2'd0;
    localparam logic [1:0] OP_DIS   = 2'd1;
    localparam logic [1:0] OP_FLUSH = 2'd2;
    localparam logic [1:0] OP_SEL   = 2'd3;

`ifdef ICACHE_INIT_FLUSH_EN
    localparam logic [2:0] RESET_STATE = WALK;
`else
    localparam logic [2:0] RESET_STATE = IDLE;
`endif

    logic [2:0]              state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [SET_ID_WIDTH-1:0] set_cnt_q;
    logic [SET_ID_WIDTH-1:0] sel_set_q;
    logic [TAG_WIDTH-1:0]    sel_tag_q;
    logic                    enabled_q;
    logic                    capture_sel;
    logic                    init_walk;
    logic [NB_WAYS-1:0]      match;
    logic [TAG_WIDTH:0]      way_entry;
    logic                    unused_offset;

    // Byte offset within a line plays no part in choosing which line to invalidate.
    assign unused_offset = ^sel_flush_addr_i[OFFSET_WIDTH-1:0];

`ifdef ICACHE_INIT_FLUSH_EN
    logic init_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_q <= 1'b1;
        end else if (state_q == WALK && set_cnt_q == '1) begin
            init_q <= 1'b0;
        end
    end

    assign init_walk = init_q;
`else
    assign init_walk = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        capture_sel = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_flush_req_i) begin
                    op_d    = OP_FLUSH;
                    state_d = DRAIN;
                end else if (sel_flush_req_i) begin
                    op_d        = OP_SEL;
                    state_d     = DRAIN;
                    capture_sel = 1'b1;
                end else if (ctrl_req_disable_i) begin
                    op_d    = OP_DIS;
                    state_d = DRAIN;
                end else if (ctrl_req_enable_i) begin
                    op_d    = OP_EN;
                    state_d = ACK;
                end
            end
            DRAIN: begin
                if (fetch_idle_i) begin
                    case (op_q)
                        OP_FLUSH: state_d = WALK;
                        OP_SEL:   state_d = SEL_RD;
                        default:  state_d = ACK;
                    endcase
                end
            end
            WALK: begin
                // The power-on walk returns silently; a requested flush must be acked.
                if (set_cnt_q == '1) begin
                    state_d = init_walk ? IDLE : ACK;
                end
            end
            SEL_RD:  state_d = SEL_CMP;
            SEL_CMP: state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RESET_STATE;
            op_q      <= OP_EN;
            set_cnt_q <= '0;
            sel_set_q <= '0;
            sel_tag_q <= '0;
            enabled_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            if (state_q == WALK) begin
                set_cnt_q <= set_cnt_q + 1'b1;
            end
            if (capture_sel) begin
                sel_set_q <= sel_flush_addr_i[OFFSET_WIDTH +: SET_ID_WIDTH];
                sel_tag_q <= sel_flush_addr_i[31 -: TAG_WIDTH];
            end
            if (state_d == ACK && state_q != ACK) begin
                if (op_d == OP_EN) begin
                    enabled_q <= 1'b1;
                end else if (op_d == OP_DIS) begin
                    enabled_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        match     = '0;
        way_entry = '0;
        for (int w = 0; w < NB_WAYS; w++) begin
            way_entry = tag_rdata_i[w*(TAG_WIDTH+1) +: TAG_WIDTH+1];
            match[w]  = way_entry[TAG_WIDTH] && (way_entry[TAG_WIDTH-1:0] == sel_tag_q);
        end
    end

    always_comb begin
        tag_req_o    = 1'b0;
        tag_we_o     = 1'b0;
        tag_addr_o   = '0;
        tag_way_be_o = '0;
        tag_wdata_o  = '0;
        case (state_q)
            WALK: begin
                tag_req_o    = 1'b1;
                tag_we_o     = 1'b1;
                tag_addr_o   = set_cnt_q;
                tag_way_be_o = '1;
            end
            SEL_RD: begin
                tag_req_o  = 1'b1;
                tag_addr_o = sel_set_q;
            end
            SEL_CMP: begin
                if (|match) begin
                    tag_req_o    = 1'b1;
                    tag_we_o     = 1'b1;
                    tag_addr_o   = sel_set_q;
                    tag_way_be_o = match;
                end
            end
            default: ;
        endcase
    end

    assign ctrl_ack_enable_o  = (state_q == ACK) && (op_q == OP_EN);
    assign ctrl_ack_disable_o = (state_q == ACK) && (op_q == OP_DIS);
    assign ctrl_flush_ack_o   = (state_q == ACK) && (op_q == OP_FLUSH);
    assign sel_flush_ack_o    = (state_q == ACK) && (op_q == OP_SEL);
    assign cache_enabled_o    = enabled_q;

    always_comb begin
        case (state_q)
            DRAIN, WALK, SEL_RD, SEL_CMP: block_fetch_o = 1'b1;
            ACK:                          block_fetch_o = (op_q != OP_EN);
            default:                      block_fetch_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_icache_bank_ctrl_seq.sv
// tb/tb_icache_bank_ctrl_seq.sv - directed self-checking bench for icache_bank_ctrl_seq
module tb_icache_bank_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_en = 1'b0, req_dis = 1'b0, req_flush = 1'b0, req_sel = 1'b0;
    logic [31:0] sel_addr = '0;
    logic        fetch_idle = 1'b1;
    logic [95:0] rdata = '0;

    logic        ack_en, ack_dis, ack_flush, ack_sel;
    logic        block, enabled, treq, twe;
    logic [4:0]  taddr;
    logic [3:0]  tbe;
    logic [23:0] twdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_bank_ctrl_seq dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .ctrl_req_enable_i  (req_en),
        .ctrl_ack_enable_o  (ack_en),
        .ctrl_req_disable_i (req_dis),
        .ctrl_ack_disable_o (ack_dis),
        .ctrl_flush_req_i   (req_flush),
        .ctrl_flush_ack_o   (ack_flush),
        .sel_flush_req_i    (req_sel),
        .sel_flush_addr_i   (sel_addr),
        .sel_flush_ack_o    (ack_sel),
        .fetch_idle_i       (fetch_idle),
        .block_fetch_o      (block),
        .cache_enabled_o    (enabled),
        .tag_req_o          (treq),
        .tag_we_o           (twe),
        .tag_addr_o         (taddr),
        .tag_way_be_o       (tbe),
        .tag_wdata_o        (twdata),
        .tag_rdata_i        (rdata)
    );

    wire [40:0] outs = {ack_en, ack_dis, ack_flush, ack_sel, block, enabled,
                        treq, twe, taddr, tbe, twdata};

    // acks = {enable, disable, flush, sel_flush}
    function automatic logic [40:0] eo(input logic [3:0] acks, input logic blk, input logic en,
                                       input logic rq, input logic we, input logic [4:0] a,
                                       input logic [3:0] be);
        return {acks, blk, en, rq, we, a, be, 24'h0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic walk_checks(input string tag, input logic en);
        for (int i = 0; i < 32; i++) begin
            step();
            check(tag, {23'h0, outs}, {23'h0, eo(4'b0000, 1'b1, en, 1'b1, 1'b1, 5'(i), 4'hF)});
        end
    endtask

    initial begin
        // reset
        step();
        check("reset_outs", {23'h0, outs}, 64'h0);
        step();
        rst = 1'b0;
        step();
        check("idle_outs", {23'h0, outs}, 64'h0);

        // enable: ack one cycle after sample, no tag access, no block
        req_en = 1'b1;
        step();
        check("en_ack", {23'h0, outs}, {23'h0, eo(4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'h0)});
        req_en = 1'b0;
        step();
        check("en_after", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'h0)});

        // full flush with fetch idle: drain, 32-set walk, ack at t+34
        req_flush = 1'b1;
        step();
        check("fl_drain", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 4'h0)});
        walk_checks("fl_walk", 1'b1);
        step();
        check("fl_ack", {23'h0, outs}, {23'h0, eo(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 4'h0)});
        req_flush = 1'b0;
        step();
        check("fl_idle", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'h0)});

        // disable while fetch busy for 5 cycles
        fetch_idle = 1'b0;
        req_dis    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("dis_drain", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 4'h0)});
        end
        fetch_idle = 1'b1;
        step();
        check("dis_ack", {23'h0, outs}, {23'h0, eo(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0)});
        req_dis = 1'b0;
        step();
        check("dis_idle", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0)});

        // selective flush hitting way 2 of set 19
        req_sel  = 1'b1;
        sel_addr = 32'h1C00_0130;
        step();
        check("sel_drain", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0)});
        sel_addr = 32'h0;
        step();
        check("sel_rd", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 5'd19, 4'h0)});
        rdata = {24'hFFFFFF, 24'h8E0000, 24'h0E0000, 24'h8E0001};
        step();
        check("sel_hit_wr", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd19, 4'b0100)});
        step();
        check("sel_hit_ack", {23'h0, outs}, {23'h0, eo(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0)});
        req_sel = 1'b0;
        step();

        // selective flush missing every way
        req_sel  = 1'b1;
        sel_addr = 32'h1C00_0130;
        step();
        step();
        check("selm_rd", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 5'd19, 4'h0)});
        rdata = {24'hFFFFFF, 24'h8E0002, 24'h0E0000, 24'h8E0001};
        step();
        check("selm_cmp", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0)});
        step();
        check("selm_ack", {23'h0, outs}, {23'h0, eo(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0)});
        req_sel = 1'b0;
        step();

        // flush and enable together: flush first, enable ack two cycles later
        req_flush = 1'b1;
        req_en    = 1'b1;
        step();
        check("fe_drain", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0)});
        walk_checks("fe_walk", 1'b0);
        step();
        check("fe_fl_ack", {23'h0, outs}, {23'h0, eo(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0)});
        req_flush = 1'b0;
        step();
        check("fe_gap", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0)});
        step();
        check("fe_en_ack", {23'h0, outs}, {23'h0, eo(4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'h0)});
        req_en = 1'b0;
        step();

        // reset in the middle of a walk, then a full reissued walk from set 0
        req_flush = 1'b1;
        step();
        for (int i = 0; i < 11; i++) begin
            step();
        end
        check("rst_walk10", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 4'hF)});
        rst       = 1'b1;
        req_flush = 1'b0;
        #1;
        check("rst_mid", {23'h0, outs}, 64'h0);
        step();
        rst = 1'b0;
        check("rst_rel", {23'h0, outs}, 64'h0);
        req_flush = 1'b1;
        step();
        check("re_drain", {23'h0, outs}, {23'h0, eo(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0)});
        walk_checks("re_walk", 1'b0);
        step();
        check("re_ack", {23'h0, outs}, {23'h0, eo(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0)});
        req_flush = 1'b0;
        step();
        check("re_idle", {23'h0, outs}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
